// File: rtl/ir_fetch_sequencer.sv
// Two-byte instruction fetch sequencer: issues byte reads (LSB then MSB), steers the
// IR write/LH strobes, pulses PC increment and holds the instruction until retired.
module ir_fetch_sequencer #(
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned CW         = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic       i_mem_ready,
   input  logic       i_exec_done,
   input  logic       i_flush,
   output logic       o_mem_cs,
   output logic       o_ir_write,
   output logic       o_ir_lh,
   output logic       o_pc_inc,
   output logic       o_instr_valid,
   output logic       o_fetch_error,
   output logic [2:0] o_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH_LSB = 3'd1,
      S_FETCH_MSB = 3'd2,
      S_EXEC      = 3'd3,
      S_ERROR     = 3'd7
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_wait_cnt;
   logic [CW-1:0]   w_wait_cnt_nxt;
   logic            w_at_limit;

   assign w_at_limit = (r_wait_cnt == CW'(WAIT_LIMIT));
   assign o_state    = r_state;

   // State and wait-counter registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   // Outputs are decoded from state and inputs so the IR latches on the state-change edge
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = '0;
      o_mem_cs       = 1'b0;
      o_ir_write     = 1'b0;
      o_ir_lh        = 1'b0;
      o_pc_inc       = 1'b0;
      o_instr_valid  = 1'b0;
      o_fetch_error  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_enable) w_state_nxt = S_FETCH_LSB;
         end

         S_FETCH_LSB, S_FETCH_MSB: begin
            o_mem_cs = 1'b1;
            o_ir_lh  = (r_state == S_FETCH_MSB);
            if (i_flush) begin
               w_state_nxt = S_FETCH_LSB;
            end else if (i_mem_ready) begin
               // A ready byte wins even when the wait counter has reached its limit
               o_ir_write  = 1'b1;
               o_pc_inc    = 1'b1;
               w_state_nxt = (r_state == S_FETCH_LSB) ? S_FETCH_MSB : S_EXEC;
            end else if (w_at_limit) begin
               w_state_nxt = S_ERROR;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + CW'(1);
            end
         end

         S_EXEC: begin
            o_instr_valid = 1'b1;
            if (i_flush) begin
               w_state_nxt = S_FETCH_LSB;
            end else if (i_exec_done) begin
               w_state_nxt = i_enable ? S_FETCH_LSB : S_IDLE;
            end
         end

         S_ERROR: begin
            o_fetch_error = 1'b1;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Bench for ir_fetch_sequencer: directed scenarios plus random traffic, all checked
// against a fetch-progress model (mode / bytes fetched / stall count).
module tb_ir_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable, mem_ready, exec_done, flush;
   logic       mem_cs, ir_write, ir_lh, pc_inc, instr_valid, fetch_error;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   // Model: 0 idle, 1 fetching, 2 holding an instruction, 3 faulted
   int m_mode = 0;
   int m_byte = 0;
   int m_wait = 0;

   always #5 clk = ~clk;

   ir_fetch_sequencer #(.WAIT_LIMIT(15), .CW(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_mem_ready(mem_ready),
      .i_exec_done(exec_done), .i_flush(flush), .o_mem_cs(mem_cs), .o_ir_write(ir_write),
      .o_ir_lh(ir_lh), .o_pc_inc(pc_inc), .o_instr_valid(instr_valid),
      .o_fetch_error(fetch_error), .o_state(state)
   );

   function automatic logic [8:0] dut_vec();
      return {state, mem_cs, ir_write, ir_lh, pc_inc, instr_valid, fetch_error};
   endfunction

   function automatic logic [8:0] model_vec();
      logic [2:0] st;
      logic cs, wr, lh, pc, vl, er;
      st = 3'd0; cs = 0; wr = 0; lh = 0; pc = 0; vl = 0; er = 0;
      if (rst_n) begin
         case (m_mode)
            1: begin
               st = (m_byte == 0) ? 3'd1 : 3'd2;
               cs = 1'b1;
               lh = (m_byte == 1);
               wr = mem_ready && !flush;
               pc = mem_ready && !flush;
            end
            2: begin st = 3'd3; vl = 1'b1; end
            3: begin st = 3'd7; er = 1'b1; end
            default: ;
         endcase
      end
      return {st, cs, wr, lh, pc, vl, er};
   endfunction

   task automatic model_update();
      if (!rst_n) begin
         m_mode = 0; m_byte = 0; m_wait = 0;
      end else begin
         case (m_mode)
            0: if (enable) begin m_mode = 1; m_byte = 0; m_wait = 0; end
            1: begin
               if (flush) begin
                  m_byte = 0; m_wait = 0;
               end else if (mem_ready) begin
                  m_wait = 0;
                  if (m_byte == 0) m_byte = 1;
                  else m_mode = 2;
               end else if (m_wait >= 15) begin
                  m_mode = 3; m_wait = 0;
               end else begin
                  m_wait = m_wait + 1;
               end
            end
            2: begin
               if (flush) begin m_mode = 1; m_byte = 0; end
               else if (exec_done) begin
                  m_mode = enable ? 1 : 0; m_byte = 0;
               end
               m_wait = 0;
            end
            default: ;
         endcase
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_in(input logic en, input logic rdy, input logic done, input logic fl);
      enable = en; mem_ready = rdy; exec_done = done; flush = fl;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_in(0, 0, 0, 0);
      advance();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_in(1, 1, 1, 1);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (dut_vec() !== 9'd0) begin
            bad++; $display("FAIL reset cyc%0d got=%b want=%b", i, dut_vec(), 9'd0);
         end
         advance();
      end
      rst_n = 1'b1;
      set_in(0, 0, 0, 0);
      total++;
      if (dut_vec() !== model_vec()) begin
         bad++; $display("FAIL reset_release got=%b want=%b", dut_vec(), model_vec());
      end
   endtask

   task automatic test_basic();
      int writes = 0;
      for (int i = 0; i < 5; i++) begin
         set_in(1, 1, 0, 0);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL basic cyc%0d got=%b want=%b", i, dut_vec(), model_vec());
         end
         writes += int'(ir_write);
         advance();
      end
      total++;
      if (writes !== 2) begin
         bad++; $display("FAIL basic_write_count got=%0d want=2", writes);
      end
      set_in(0, 1, 1, 0);
      advance();
      total++;
      if (dut_vec() !== model_vec() || state !== 3'd0) begin
         bad++; $display("FAIL basic_retire got=%b want=%b", dut_vec(), model_vec());
      end
   endtask

   task automatic test_wait_lsb();
      set_in(1, 0, 0, 0);
      advance();
      for (int i = 0; i < 5; i++) begin
         set_in(1, (i >= 3), 0, 0);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL wait_lsb cyc%0d got=%b want=%b", i, dut_vec(), model_vec());
         end
         advance();
      end
      total++;
      if (state !== 3'd3) begin
         bad++; $display("FAIL wait_lsb_state got=%0d want=3", state);
      end
      do_reset();
   endtask

   task automatic test_timeout();
      set_in(1, 1, 0, 0);
      advance();
      advance();
      for (int i = 0; i < 20; i++) begin
         set_in(1, 0, 0, 0);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL timeout cyc%0d got=%b want=%b", i, dut_vec(), model_vec());
         end
         advance();
      end
      for (int i = 0; i < 6; i++) begin
         set_in(i[0], 1, i[1], ~i[0]);
         total++;
         if (fetch_error !== 1'b1 || state !== 3'd7 || dut_vec() !== model_vec()) begin
            bad++; $display("FAIL timeout_sticky cyc%0d got=%b want=%b", i, dut_vec(), model_vec());
         end
         advance();
      end
      do_reset();
      total++;
      if (fetch_error !== 1'b0) begin
         bad++; $display("FAIL timeout_clear got=%b want=0", fetch_error);
      end
   endtask

   task automatic test_flush();
      set_in(1, 1, 0, 0);
      advance();
      advance();
      set_in(1, 1, 0, 1);
      total++;
      if (dut_vec() !== model_vec() || ir_write !== 1'b0 || pc_inc !== 1'b0) begin
         bad++; $display("FAIL flush_msb got=%b want=%b", dut_vec(), model_vec());
      end
      advance();
      set_in(1, 1, 0, 0);
      total++;
      if (dut_vec() !== model_vec() || state !== 3'd1) begin
         bad++; $display("FAIL flush_next got=%b want=%b", dut_vec(), model_vec());
      end
      advance();
      advance();
      set_in(1, 0, 1, 1);
      total++;
      if (dut_vec() !== model_vec()) begin
         bad++; $display("FAIL flush_exec got=%b want=%b", dut_vec(), model_vec());
      end
      advance();
      total++;
      if (state !== 3'd1) begin
         bad++; $display("FAIL flush_exec_next got=%0d want=1", state);
      end
      do_reset();
   endtask

   task automatic test_enable_drop();
      set_in(1, 0, 0, 0);
      advance();
      for (int i = 0; i < 8; i++) begin
         set_in(0, (i != 0), (i >= 5), 0);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL enable_drop cyc%0d got=%b want=%b", i, dut_vec(), model_vec());
         end
         advance();
      end
      total++;
      if (state !== 3'd0 || mem_cs !== 1'b0) begin
         bad++; $display("FAIL enable_drop_idle got=%0d/%b want=0/0", state, mem_cs);
      end
   endtask

   task automatic test_async_reset();
      set_in(1, 1, 0, 0);
      advance();
      advance();
      set_in(1, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (dut_vec() !== 9'd0) begin
         bad++; $display("FAIL async_reset got=%b want=%b", dut_vec(), 9'd0);
      end
      advance();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_random();
      int stall = 0;
      int fault_cycles = 0;
      for (int i = 0; i < 3000; i++) begin
         if (stall == 0 && $urandom_range(0, 99) == 0) stall = $urandom_range(10, 20);
         rst_n = (fault_cycles > 4) ? 1'b0 : 1'b1;
         set_in(($urandom_range(0, 7) != 0), (stall == 0) && ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0));
         if (stall > 0) stall--;
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL random cyc%0d got=%b want=%b", i, dut_vec(), model_vec());
         end
         fault_cycles = (m_mode == 3) ? fault_cycles + 1 : 0;
         advance();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 0; mem_ready = 0; exec_done = 0; flush = 0;
      #2;
      test_reset();
      test_basic();
      test_wait_lsb();
      test_timeout();
      test_flush();
      test_enable_drop();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
